morse_tx: RTL and testbench

//  Morse keyer: takes one encoded character per handshake and emits the timed
//  on/off key waveform (dot=1 unit, dash=3, element gap=1, letter gap=3, word
//  gap=7). Built on the same unit-time counting as tim_counter, in the opposite

---
 rtl/morse_tx.sv | 188 ++++++++++++++++++
 tb/tb_morse_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/morse_tx.sv
// -----------------------------------------------------------------------------
// morse_tx -- Morse keyer.
//
// Accepts one encoded character per valid/ready handshake and produces the
// timed on/off key waveform: dot = 1 unit, dash = 3 units, element gap =
// 1 unit, letter gap = 3 units, word gap = 7 units. One unit is UNIT_CYCLES
// clock cycles.
//
// Ports:
//   clk        in   1        system clock, rising edge
//   reset      in   1        asynchronous reset, active-low
//   sym_valid  in   1        character pattern offered
//   sym_ready  out  1        block can accept (high only while idle)
//   sym_len    in   3        element count; values above MAX_LEN clamp
//   sym_bits   in   MAX_LEN  element code, bit0 first; 1 = dash, 0 = dot
//   word_end   in   1        trailing gap is 7 units instead of 3
//   abort      in   1        (MORSE_TX_ABORT_EN only) drop the current character
//   key        out  1        keyed output, 1 = tone/LED on
//   busy       out  1        character in progress
//   done       out  1        pulse on the final cycle of the trailing gap
//
// Build option: define MORSE_TX_ABORT_EN to add the abort input.
// -----------------------------------------------------------------------------
module morse_tx #(
  parameter int UNIT_CYCLES = 10,
  parameter int CNT_W       = 8,
  parameter int MAX_LEN     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sym_valid,
  output logic               sym_ready,
  input  logic [2:0]         sym_len,
  input  logic [MAX_LEN-1:0] sym_bits,
  input  logic               word_end,
`ifdef MORSE_TX_ABORT_EN
  input  logic               abort,
`endif
  output logic               key,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   pres, pres_d;
  logic [2:0]         unit, unit_d;
  logic [2:0]         elem, elem_d;
  logic [MAX_LEN-1:0] bits, bits_d;
  logic               wend, wend_d;
  logic               unit_tick;
  logic               abort_req;
  logic               done_d;

  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    return (l > 3'(MAX_LEN)) ? 3'(MAX_LEN) : l;
  endfunction

  function automatic logic [2:0] mark_units(input logic is_dash);
    return is_dash ? 3'd3 : 3'd1;
  endfunction

  function automatic logic [2:0] gap_units(input logic is_word);
    return is_word ? 3'd7 : 3'd3;
  endfunction

`ifdef MORSE_TX_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign sym_ready = (state == IDLE);
  assign unit_tick = (pres == CNT_W'(UNIT_CYCLES - 1));

  always_comb begin
    state_d = state;
    pres_d  = pres;
    unit_d  = unit;
    elem_d  = elem;
    bits_d  = bits;
    wend_d  = wend;

    // Free-running unit timing inside a state; every state change below
    // restarts both counters so no partial unit carries over.
    if (unit_tick) begin
      pres_d = '0;
      unit_d = unit + 3'd1;
    end else begin
      pres_d = pres + 1'b1;
    end

    case (state)
      IDLE: begin
        pres_d = '0;
        unit_d = '0;
        // An abort in the same cycle suppresses the accept.
        if (sym_valid && !abort_req) begin
          bits_d  = sym_bits;
          wend_d  = word_end;
          elem_d  = clamp_len(sym_len);
          state_d = (clamp_len(sym_len) != 3'd0) ? MARK : GAP;
        end
      end
      MARK: begin
        if (unit_tick && (unit == mark_units(bits[0]) - 3'd1)) begin
          pres_d = '0;
          unit_d = '0;
          if (elem > 3'd1) begin
            state_d = SPACE;
            elem_d  = elem - 3'd1;
            bits_d  = bits >> 1;
          end else begin
            // Last element goes straight to the trailing gap; the
            // inter-element space is not part of it.
            state_d = GAP;
            elem_d  = '0;
          end
        end
      end
      SPACE: begin
        if (unit_tick) begin
          pres_d  = '0;
          unit_d  = '0;
          state_d = MARK;
        end
      end
      GAP: begin
        if (unit_tick && (unit == gap_units(wend) - 3'd1)) begin
          pres_d  = '0;
          unit_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        pres_d  = '0;
        unit_d  = '0;
      end
    endcase

    if (abort_req && (state != IDLE)) begin
      state_d = IDLE;
      pres_d  = '0;
      unit_d  = '0;
      elem_d  = '0;
    end
  end

  // done is registered: raise it when the next cycle is the last cycle of GAP.
  assign done_d = (state_d == GAP) &&
                  (pres_d == CNT_W'(UNIT_CYCLES - 1)) &&
                  (unit_d == gap_units(wend_d) - 3'd1);

  // ---- control / output register stage ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pres  <= '0;
      unit  <= '0;
      elem  <= '0;
      key   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      pres  <= pres_d;
      unit  <= unit_d;
      elem  <= elem_d;
      key   <= (state_d == MARK);
      busy  <= (state_d != IDLE);
      done  <= done_d;
    end
  end

  // ---- latched character data ----
  always_ff @(posedge clk) begin
    bits <= bits_d;
    wend <= wend_d;
  end

endmodule

// File: tb/tb_morse_tx.sv
// -----------------------------------------------------------------------------
// tb_morse_tx -- self-checking bench for morse_tx with UNIT_CYCLES = 4.
// Each accepted character pushes its expected per-cycle key/done waveform to a
// queue; the monitor pops one entry per cycle and compares.
// -----------------------------------------------------------------------------
module tb_morse_tx;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sym_valid = 1'b0;
  logic       sym_ready;
  logic [2:0] sym_len = '0;
  logic [4:0] sym_bits = '0;
  logic       word_end = 1'b0;
  logic       key, busy, done;
`ifdef MORSE_TX_ABORT_EN
  logic       abort = 1'b0;
`endif

  morse_tx #(.UNIT_CYCLES(U), .CNT_W(8), .MAX_LEN(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_len   (sym_len),
    .sym_bits  (sym_bits),
    .word_end  (word_end),
`ifdef MORSE_TX_ABORT_EN
    .abort     (abort),
`endif
    .key       (key),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic k;
    logic d;
  } ent_t;

  ent_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Expected waveform of one character, starting the cycle after accept.
  task automatic push_char(input int len, input logic [4:0] b, input logic w);
    int l, n, g;
    l = (len > 5) ? 5 : len;
    for (int i = 0; i < l; i++) begin
      n = b[i] ? 3 : 1;
      for (int c = 0; c < n * U; c++) q.push_back('{k: 1'b1, d: 1'b0});
      if (i < l - 1)
        for (int c = 0; c < U; c++) q.push_back('{k: 1'b0, d: 1'b0});
    end
    g = (w ? 7 : 3) * U;
    for (int c = 0; c < g; c++) q.push_back('{k: 1'b0, d: (c == g - 1)});
  endtask

  // Monitor: {key,busy,done,sym_ready} every cycle on the falling edge.
  always @(negedge clk) begin
    ent_t e;
    if (!reset) begin
      q.delete();
      chk("reset_out", {key, busy, done, sym_ready}, 4'b0001);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk("wave", {key, busy, done, sym_ready}, {e.k, 1'b1, e.d, 1'b0});
    end else begin
      chk("idle", {key, busy, done, sym_ready}, 4'b0001);
    end
  end

  // Offer a character until accepted; returns the cycle number of the accept edge.
  task automatic send(input int len, input logic [4:0] b, input logic w,
                      input logic hold, output int acc);
    int i;
    @(negedge clk); #1;
    sym_len   = 3'(len);
    sym_bits  = b;
    word_end  = w;
    sym_valid = 1'b1;
    for (i = 0; i < 300 && !sym_ready; i++) begin
      @(negedge clk); #1;
    end
    if (!sym_ready) chk("accept_timeout", sym_ready, 1);
    push_char(len, b, w);
    @(posedge clk); #1;
    acc = cyc;
    if (!hold) sym_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int a0, a1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;

    send(1, 5'b00000, 1'b0, 1'b0, a0);   // E
    wait_idle();
    send(2, 5'b00010, 1'b0, 1'b0, a0);   // A
    wait_idle();
    send(0, 5'b00000, 1'b1, 1'b0, a0);   // pure word space
    wait_idle();
    send(7, 5'b10101, 1'b1, 1'b0, a0);   // length clamps to 5
    wait_idle();
    send(3, 5'b00101, 1'b1, 1'b0, a0);   // K with word gap
    wait_idle();

    // E then T with sym_valid held: only the single idle cycle in between.
    send(1, 5'b00000, 1'b0, 1'b1, a0);
    send(1, 5'b00001, 1'b0, 1'b0, a1);
    chk("b2b_accept_spacing", a1 - a0, 4 * U + 1);
    wait_idle();

    // Asynchronous reset during the 2nd dash unit of T.
    send(1, 5'b00001, 1'b0, 1'b0, a0);
    repeat (5) @(negedge clk);
    #1 reset = 1'b0;
    #1 chk("async_key_drop", {key, busy, done}, 3'b000);
    @(negedge clk); #1;
    reset = 1'b1;
    repeat (4) @(negedge clk);

`ifdef MORSE_TX_ABORT_EN
    send(2, 5'b00010, 1'b0, 1'b0, a0);
    repeat (2) @(negedge clk);
    #1 abort = 1'b1;
    q.delete();
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_state", {key, busy, done, sym_ready}, 4'b0001);
    repeat (4) @(negedge clk);
`endif

    send(1, 5'b00000, 1'b0, 1'b0, a0);   // recovers normally afterwards
    wait_idle();
    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
